// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: FP op codes and the stall FSM state encoding.
package cpu_pipe_pkg;

  localparam logic [2:0] FP_NOP = 3'd0;
  localparam logic [2:0] FP_ADD = 3'd1;
  localparam logic [2:0] FP_SUB = 3'd2;
  localparam logic [2:0] FP_MUL = 3'd3;
  localparam logic [2:0] FP_DIV = 3'd4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    FP_BUSY = 1'b1
  } hsu_state_e;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage operand info, EX-stage producer info and the stall/bubble controls.
interface hazard_stall_unit_if;
  logic [4:0] rsId;
  logic [4:0] rtId;
  logic       useRsId;
  logic       useRtId;
  logic [4:0] rWEx;
  logic       memReadEx;
  logic       regWrEx;
  logic [2:0] fp_exCtrlEx;
  logic       pcWrite;
  logic       ifIdWrite;
  logic       idExWrite;
  logic       idExBubble;
  logic       fpBusy;

  modport master (
    output rsId, rtId, useRsId, useRtId, rWEx, memReadEx, regWrEx, fp_exCtrlEx,
    input  pcWrite, ifIdWrite, idExWrite, idExBubble, fpBusy
  );

  modport slave (
    input  rsId, rtId, useRsId, useRtId, rWEx, memReadEx, regWrEx, fp_exCtrlEx,
    output pcWrite, ifIdWrite, idExWrite, idExBubble, fpBusy
  );
endinterface

// File: rtl/fp_latency_counter.sv
// Down-counter tracking the remaining EX occupancy of a multi-cycle FP op.
// done marks the last cycle the op holds EX.
module fp_latency_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Load on FP op entry, count down while busy, never wrap below zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == W'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard unit: freezes the front end for multi-cycle FP ops in EX
// and inserts a one-cycle bubble for integer load-use dependencies.
module hazard_stall_unit
  import cpu_pipe_pkg::*;
#(
  parameter int FP_ADD_LAT = 2,
  parameter int FP_MUL_LAT = 4,
  parameter int FP_DIV_LAT = 12
) (
  input logic               clk,
  input logic               rst_n,
  hazard_stall_unit_if.slave hz
);

  localparam int MAX_AM  = (FP_ADD_LAT > FP_MUL_LAT) ? FP_ADD_LAT : FP_MUL_LAT;
  localparam int MAX_LAT = (MAX_AM > FP_DIV_LAT) ? MAX_AM : FP_DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // EX occupancy of an FP op; anything that is not a real FP op takes one cycle.
  function automatic cnt_t lat_of(input logic [2:0] op);
    cnt_t lat_v;
    case (op)
      FP_ADD, FP_SUB: lat_v = cnt_t'(FP_ADD_LAT);
      FP_MUL:         lat_v = cnt_t'(FP_MUL_LAT);
      FP_DIV:         lat_v = cnt_t'(FP_DIV_LAT);
      default:        lat_v = cnt_t'(1);
    endcase
    return lat_v;
  endfunction

  hsu_state_e state_r;
  hsu_state_e state_nxt_s;
  cnt_t       lat_s;
  logic       frozen_s;
  logic       cnt_load_s;
  logic       cnt_dec_s;
  logic       cnt_done_s;
  logic       load_use_s;

  assign lat_s = lat_of(hz.fp_exCtrlEx);

  fp_latency_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .load_val (lat_s - cnt_t'(1)),
    .dec      (cnt_dec_s),
    .done     (cnt_done_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and freeze decision: entry cycle and all busy cycles except the last freeze.
  always_comb begin
    state_nxt_s = state_r;
    frozen_s    = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (lat_s > cnt_t'(1)) begin
          state_nxt_s = FP_BUSY;
          frozen_s    = 1'b1;
          cnt_load_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FP_BUSY: begin
        cnt_dec_s = 1'b1;
        if (cnt_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          frozen_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Integer load-use: the loaded register (never r0) is read by the ID instruction.
  always_comb begin
    load_use_s = hz.memReadEx && hz.regWrEx && (hz.rWEx != 5'd0) &&
                 ((hz.useRsId && (hz.rsId == hz.rWEx)) ||
                  (hz.useRtId && (hz.rtId == hz.rWEx)));
  end

  // Output mux: FP freeze outranks the load-use bubble.
  always_comb begin
    hz.pcWrite    = 1'b1;
    hz.ifIdWrite  = 1'b1;
    hz.idExWrite  = 1'b1;
    hz.idExBubble = 1'b0;
    hz.fpBusy     = 1'b0;
    if (frozen_s) begin
      hz.pcWrite   = 1'b0;
      hz.ifIdWrite = 1'b0;
      hz.idExWrite = 1'b0;
      hz.fpBusy    = 1'b1;
    end else if (load_use_s) begin
      hz.pcWrite    = 1'b0;
      hz.ifIdWrite  = 1'b0;
      hz.idExBubble = 1'b1;
    end else begin
      hz.pcWrite = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an occupancy model.
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_stall_unit_if hz_if ();

  hazard_stall_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if)
  );

  int checks = 0;
  int errors = 0;
  int occ = 0;          // cycles the current FP op still holds EX after this one
  bit model_valid = 1'b0;

  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return 2;
      3'd3:       return 4;
      3'd4:       return 12;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [4:0] got_outs();
    return {hz_if.pcWrite, hz_if.ifIdWrite, hz_if.idExWrite, hz_if.idExBubble, hz_if.fpBusy};
  endfunction

  // Expected {pcWrite, ifIdWrite, idExWrite, idExBubble, fpBusy}
  function automatic logic [4:0] model_outs();
    bit frozen;
    bit lu;
    frozen = ((occ == 0) && (lat_of(hz_if.fp_exCtrlEx) > 1)) || (occ > 1);
    lu = hz_if.memReadEx && hz_if.regWrEx && (hz_if.rWEx != 5'd0) &&
         ((hz_if.useRsId && hz_if.rsId == hz_if.rWEx) ||
          (hz_if.useRtId && hz_if.rtId == hz_if.rWEx));
    if (frozen)  return 5'b00001;
    else if (lu) return 5'b00110;
    else         return 5'b11100;
  endfunction

  // Model: an accepted op of latency L holds EX for L cycles; the last is the release.
  always @(posedge clk) begin
    if (!rst_n) begin
      occ <= 0;
      model_valid <= 1'b1;
    end else if (occ == 0) begin
      occ <= (lat_of(hz_if.fp_exCtrlEx) > 1) ? lat_of(hz_if.fp_exCtrlEx) - 1 : 0;
    end else begin
      occ <= occ - 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (got_outs() !== model_outs()) begin
        errors++;
        $display("FAIL model t=%0t: got %b, expected %b", $time, got_outs(), model_outs());
      end
    end
  end

  task automatic set_lu(input bit mr, input bit rw, input logic [4:0] rd,
                        input bit urs, input logic [4:0] rs,
                        input bit urt, input logic [4:0] rt);
    hz_if.memReadEx = mr; hz_if.regWrEx = rw; hz_if.rWEx = rd;
    hz_if.useRsId = urs; hz_if.rsId = rs; hz_if.useRtId = urt; hz_if.rtId = rt;
  endtask

  task automatic step(input string name, input logic [4:0] exp);
    @(negedge clk);
    checks++;
    if (got_outs() !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got_outs(), exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hz_if.fp_exCtrlEx = 3'd0;
    set_lu(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    step("reset_1", 5'b11100);
    step("reset_2", 5'b11100);
    rst_n = 1'b1;
    step("post_reset", 5'b11100);

    set_lu(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
    step("load_use_rs", 5'b00110);
    hz_if.memReadEx = 1'b0;
    step("load_use_clear", 5'b11100);
    set_lu(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    step("load_use_r0", 5'b11100);
    set_lu(1'b1, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 5'd7);
    step("load_use_rt", 5'b00110);
    hz_if.useRtId = 1'b0;
    step("load_use_unused_rt", 5'b11100);
    set_lu(1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
    step("load_no_regwr", 5'b11100);
    set_lu(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);

    hz_if.fp_exCtrlEx = 3'd3;
    for (int i = 0; i < 3; i++) step("mul_freeze", 5'b00001);
    step("mul_release", 5'b11100);
    hz_if.fp_exCtrlEx = 3'd0;
    step("mul_after", 5'b11100);

    hz_if.fp_exCtrlEx = 3'd4;
    for (int i = 0; i < 11; i++) step("div_freeze", 5'b00001);
    step("div_release", 5'b11100);

    hz_if.fp_exCtrlEx = 3'd3;
    for (int i = 0; i < 3; i++) step("b2b_mul_freeze", 5'b00001);
    step("b2b_mul_release", 5'b11100);
    hz_if.fp_exCtrlEx = 3'd1;
    step("b2b_add_entry", 5'b00001);
    step("b2b_add_release", 5'b11100);
    hz_if.fp_exCtrlEx = 3'd0;
    step("b2b_after", 5'b11100);

    hz_if.fp_exCtrlEx = 3'd3;
    set_lu(1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) step("mul_lu_freeze", 5'b00001);
    step("mul_lu_release_bubble", 5'b00110);
    hz_if.fp_exCtrlEx = 3'd0;
    set_lu(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step("mul_lu_after", 5'b11100);

    hz_if.fp_exCtrlEx = 3'd4;
    step("div_rst_entry", 5'b00001);
    step("div_rst_busy", 5'b00001);
    rst_n = 1'b0;
    hz_if.fp_exCtrlEx = 3'd0;
    step("div_rst_cycle", 5'b00001);
    rst_n = 1'b1;
    step("div_rst_after", 5'b11100);

    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      hz_if.fp_exCtrlEx = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      set_lu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
